// File: rtl/clk_period_watcher.sv
// Measures each clk_lo period from a free-running timestamp and pulses change_o when the
// period leaves the tolerance window around the last reported value. Min/max stats: CLK_PERIOD_WATCHER_STATS_EN.
module clk_period_watcher #(
  parameter int unsigned time_width_p  = 32,
  parameter int unsigned tolerance_p   = 1,
  parameter int unsigned count_width_p = 16
) (
  input  logic                     clk_lo,
  input  logic                     tag_reset,
  input  logic [time_width_p-1:0]  time_i,
  output logic [time_width_p-1:0]  period_o,
  output logic                     period_v_o,
  output logic [time_width_p-1:0]  reported_o,
  output logic                     change_o,
  output logic [count_width_p-1:0] change_count_o,
  output logic [time_width_p-1:0]  min_period_o,
  output logic [time_width_p-1:0]  max_period_o
);

  localparam int unsigned TW = time_width_p;
  localparam int unsigned CW = count_width_p;
  localparam logic [TW-1:0] TOL = TW'(tolerance_p);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [TW-1:0] last_time;
  logic [TW-1:0] last_time_next;
  logic [TW-1:0] period_next;
  logic          period_v_next;
  logic [TW-1:0] reported_next;
  logic          change_next;
  logic [CW-1:0] count_next;

  logic [TW-1:0] period_now;
  logic [TW-1:0] deviation;
  logic          measuring;

  // Modulo subtraction absorbs timestamp wrap-around.
  assign period_now = time_i - last_time;
  assign deviation  = (period_now >= reported_o) ? (period_now - reported_o)
                                                 : (reported_o - period_now);
  assign measuring  = (state == ARMED) || (state == RUN);

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state;
    last_time_next = last_time;
    period_next    = period_o;
    period_v_next  = period_v_o;
    reported_next  = reported_o;
    change_next    = 1'b0;
    count_next     = change_count_o;

    case (state)
      IDLE: begin
        last_time_next = time_i;
        state_next     = ARMED;
      end
      ARMED: begin
        last_time_next = time_i;
        period_next    = period_now;
        period_v_next  = 1'b1;
        reported_next  = period_now;
        change_next    = 1'b1;
        count_next     = CW'(1);
        state_next     = RUN;
      end
      RUN: begin
        last_time_next = time_i;
        period_next    = period_now;
        // Compared against the reported reference, so slow drift accumulates.
        if (deviation > TOL) begin
          change_next   = 1'b1;
          reported_next = period_now;
          if (change_count_o != CNT_MAX) begin
            count_next = change_count_o + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_lo or negedge tag_reset) begin
    if (!tag_reset) begin
      state          <= IDLE;
      last_time      <= '0;
      period_o       <= '0;
      period_v_o     <= 1'b0;
      reported_o     <= '0;
      change_o       <= 1'b0;
      change_count_o <= '0;
    end else begin
      state          <= state_next;
      last_time      <= last_time_next;
      period_o       <= period_next;
      period_v_o     <= period_v_next;
      reported_o     <= reported_next;
      change_o       <= change_next;
      change_count_o <= count_next;
    end
  end

`ifdef CLK_PERIOD_WATCHER_STATS_EN
  // Running extremes over every measured period since reset.
  always_ff @(posedge clk_lo or negedge tag_reset) begin
    if (!tag_reset) begin
      min_period_o <= '1;
      max_period_o <= '0;
    end else if (measuring) begin
      if (period_now < min_period_o) begin
        min_period_o <= period_now;
      end
      if (period_now > max_period_o) begin
        max_period_o <= period_now;
      end
    end
  end
`else
  logic unused_measuring;
  assign unused_measuring = measuring;
  assign min_period_o     = '0;
  assign max_period_o     = '0;
`endif

endmodule

// File: tb/tb_clk_period_watcher.sv
// Scoreboard bench for clk_period_watcher: stimulus queues expected outputs per edge,
// a monitor pops and compares after each posedge or asynchronous reset.
module tb_clk_period_watcher;

  localparam int unsigned TW = 32;
  localparam int unsigned CW = 16;
  localparam logic [TW-1:0] TOL = 32'd1;
`ifdef CLK_PERIOD_WATCHER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_lo = 1'b0;
  logic          tag_reset;
  logic [TW-1:0] time_i;
  logic [TW-1:0] period_o;
  logic          period_v_o;
  logic [TW-1:0] reported_o;
  logic          change_o;
  logic [CW-1:0] change_count_o;
  logic [TW-1:0] min_period_o;
  logic [TW-1:0] max_period_o;

  clk_period_watcher #(
    .time_width_p (TW),
    .tolerance_p  (1),
    .count_width_p(CW)
  ) dut (
    .clk_lo        (clk_lo),
    .tag_reset     (tag_reset),
    .time_i        (time_i),
    .period_o      (period_o),
    .period_v_o    (period_v_o),
    .reported_o    (reported_o),
    .change_o      (change_o),
    .change_count_o(change_count_o),
    .min_period_o  (min_period_o),
    .max_period_o  (max_period_o)
  );

  always #5 clk_lo = ~clk_lo;

  typedef struct packed {
    logic [TW-1:0] period;
    logic          v;
    logic [TW-1:0] rep;
    logic          chg;
    logic [CW-1:0] cnt;
    logic [TW-1:0] mn;
    logic [TW-1:0] mx;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_seen = 0;

  // Reference model state
  int            m_state;
  logic [TW-1:0] m_last, m_period, m_rep, m_min, m_max;
  logic          m_v, m_chg;
  logic [CW-1:0] m_cnt;

  task automatic model_reset();
    m_state = 0; m_last = '0; m_period = '0; m_rep = '0;
    m_v = 1'b0; m_chg = 1'b0; m_cnt = '0;
    m_min = STATS ? '1 : '0;
    m_max = '0;
  endtask

  task automatic model_step(input logic [TW-1:0] t);
    logic [TW-1:0] p, d;
    p = t - m_last;
    if (m_state == 0) begin
      m_last = t;
      m_state = 1;
    end else begin
      m_period = p;
      m_last = t;
      if (m_state == 1) begin
        m_v = 1'b1; m_rep = p; m_chg = 1'b1; m_cnt = 16'd1; m_state = 2;
      end else begin
        d = (p > m_rep) ? p - m_rep : m_rep - p;
        m_chg = (d > TOL);
        if (m_chg) begin
          m_rep = p;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
      if (STATS) begin
        if (p < m_min) m_min = p;
        if (p > m_max) m_max = p;
      end
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.period = m_period; e.v = m_v; e.rep = m_rep; e.chg = m_chg;
    e.cnt = m_cnt; e.mn = m_min; e.mx = m_max;
    return e;
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] req);
    n_chk++;
    if (got === req) n_pass++;
    else $display("FAIL %s sample %0d: got %0h, required %0h", name, n_seen, got, req);
  endtask

  // Monitor: compare outputs after each edge or asynchronous reset event
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_lo or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_seen++;
        chk("period", period_o, e.period);
        chk("period_v", 32'(period_v_o), 32'(e.v));
        chk("reported", reported_o, e.rep);
        chk("change", 32'(change_o), 32'(e.chg));
        chk("change_count", 32'(change_count_o), 32'(e.cnt));
        chk("min_period", min_period_o, e.mn);
        chk("max_period", max_period_o, e.mx);
      end
    end
  end

  task automatic tick(input logic [TW-1:0] t);
    @(negedge clk_lo);
    time_i = t;
    if (tag_reset) model_step(t);
    exp_q.push_back(model_snapshot());
    @(posedge clk_lo);
  endtask

  task automatic assert_reset();
    #3;
    tag_reset = 1'b0;
    model_reset();
    exp_q.push_back(model_snapshot());
    ->sample_ev;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t;
    tag_reset = 1'b0;
    time_i    = '0;
    model_reset();
    #2;
    exp_q.push_back(model_snapshot());
    ->sample_ev;
    tick(32'd0);
    tick(32'd0);
    #3 tag_reset = 1'b1;

    // Steady 10000: one change at second edge, then 100 quiet edges
    t = 32'd1000;
    tick(t);
    for (int i = 0; i < 101; i++) begin t = t + 32'd10000; tick(t); end
    // Jitter within tolerance
    for (int i = 0; i < 20; i++) begin t = t + ((i % 2) ? 32'd10000 : 32'd10001); tick(t); end
    // Frequency step and back
    for (int i = 0; i < 10; i++) begin t = t + 32'd7500; tick(t); end
    for (int i = 0; i < 5; i++) begin t = t + 32'd10000; tick(t); end
    // Deviation of tolerance+1 is a change
    t = t + 32'd10002; tick(t);
    t = t + 32'd10000; tick(t);
    // Timestamp wrap
    tick(32'hFFFF_C8F0);
    tick(32'hFFFF_F000);
    t = 32'h0000_1710; tick(t);
    // Zero period
    tick(t);
    t = t + 32'd10000; tick(t);
    // Reset mid-RUN
    assert_reset();
    t = t + 32'd10000; tick(t);
    t = t + 32'd10000; tick(t);
    #3 tag_reset = 1'b1;
    t = t + 32'd10000; tick(t);
    t = t + 32'd10000; tick(t);
    // Stats sequence 10000, 5000, 20000
    t = t + 32'd5000;  tick(t);
    t = t + 32'd20000; tick(t);

    #2;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_lo);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
